// File: rtl/sevenseg_pkg.sv
// Shared types and defaults for the seven-segment scan controller.
package sevenseg_pkg;

    typedef enum logic [0:0] {
        GAP = 1'b0,
        ON  = 1'b1
    } scan_state_t;

    localparam int DEF_NUM_DIGITS  = 4;
    localparam int DEF_REFRESH_DIV = 100000;
    localparam int DEF_GAP_CYCLES  = 1000;

    // All anodes dark for an n-digit display (n in 1..32); callers truncate to their width.
    function automatic logic [31:0] ANODE_OFF(input int n);
        logic [31:0] mask_s;
        mask_s = 32'hFFFF_FFFF >> (6'd32 - n[5:0]);
        return mask_s;
    endfunction

endpackage

// File: rtl/ss_refresh_timer.sv
// Phase timer for the display scan: alternates a GAP phase of GAP_LEN cycles
// with an ON phase of ON_LEN cycles, starting in GAP after reset.
module ss_refresh_timer
    import sevenseg_pkg::*;
#(
    parameter int ON_LEN  = DEF_REFRESH_DIV,
    parameter int GAP_LEN = DEF_GAP_CYCLES
) (
    input  logic clk,
    input  logic reset,
    output logic phase_on,
    output logic phase_last
);

    localparam int MAX_LEN = (ON_LEN > GAP_LEN) ? ON_LEN : GAP_LEN;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);

    scan_state_t   state_r;
    scan_state_t   state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;

    // State and cycle counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= GAP;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next state: swap phase and restart the count on a phase's last cycle
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CW'(1'b1);
        case (state_r)
            GAP: begin
                if (phase_last) begin
                    state_nxt_s = ON;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    state_nxt_s = GAP;
                end
            end
            ON: begin
                if (phase_last) begin
                    state_nxt_s = GAP;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    state_nxt_s = ON;
                end
            end
            default: begin
                state_nxt_s = GAP;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Phase flags decoded from the registered state
    always_comb begin
        phase_on   = 1'b0;
        phase_last = 1'b0;
        case (state_r)
            GAP: begin
                phase_on   = 1'b0;
                phase_last = (cnt_r == GAP_LAST);
            end
            ON: begin
                phase_on   = 1'b1;
                phase_last = (cnt_r == ON_LAST);
            end
            default: begin
                phase_on   = 1'b0;
                phase_last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit (parameterisable) common-anode scan controller with a frame-synchronous
// double buffer. Define SS_LEADING_ZERO_BLANK_EN to also darken leading zero digits.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic                          load,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic [3:0]                    data,
    output logic [NUM_DIGITS-1:0]         Anode_Activate,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          pending,
    output logic                          frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] ALL_OFF  = NUM_DIGITS'(ANODE_OFF(NUM_DIGITS));
    localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);

    logic                  phase_on_s;
    logic                  phase_last_s;
    logic                  adv_s;
    logic                  frame_done_s;
    logic                  on_nxt_s;
    logic [IW-1:0]         idx_r;
    logic [IW-1:0]         idx_nxt_s;
    logic [DW-1:0]         disp_r;
    logic [DW-1:0]         disp_nxt_s;
    logic [DW-1:0]         pend_r;
    logic [DW-1:0]         pend_nxt_s;
    logic                  pend_v_r;
    logic                  pend_v_nxt_s;
    logic [NUM_DIGITS-1:0] anode_r;
    logic [NUM_DIGITS-1:0] anode_nxt_s;
    logic [NUM_DIGITS-1:0] lz_blank_s;
    logic [3:0]            data_r;

    ss_refresh_timer #(
        .ON_LEN  (REFRESH_DIV),
        .GAP_LEN (GAP_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .phase_on   (phase_on_s),
        .phase_last (phase_last_s)
    );

`ifdef SS_LEADING_ZERO_BLANK_EN
    // Digit i>0 is dark when it and every higher nibble of the upcoming word are zero
    always_comb begin
        logic zero_above_s;
        lz_blank_s   = {NUM_DIGITS{1'b0}};
        zero_above_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above_s  = zero_above_s & (disp_nxt_s[4*i +: 4] == 4'h0);
            lz_blank_s[i] = zero_above_s;
        end
    end
`else
    assign lz_blank_s = {NUM_DIGITS{1'b0}};
`endif

    // Digit advance and double-buffer commit at the frame boundary
    always_comb begin
        adv_s        = phase_on_s & phase_last_s;
        frame_done_s = adv_s & (idx_r == LAST_IDX);
        on_nxt_s     = phase_last_s ? ~phase_on_s : phase_on_s;
        if (adv_s) begin
            if (idx_r == LAST_IDX) begin
                idx_nxt_s = {IW{1'b0}};
            end else begin
                idx_nxt_s = idx_r + IW'(1'b1);
            end
        end else begin
            idx_nxt_s = idx_r;
        end
        if (load) begin
            pend_nxt_s = digits_in;
        end else begin
            pend_nxt_s = pend_r;
        end
        // A load coinciding with the commit bypasses the pending buffer
        if (frame_done_s) begin
            pend_v_nxt_s = 1'b0;
            if (load) begin
                disp_nxt_s = digits_in;
            end else if (pend_v_r) begin
                disp_nxt_s = pend_r;
            end else begin
                disp_nxt_s = disp_r;
            end
        end else begin
            pend_v_nxt_s = pend_v_r | load;
            disp_nxt_s   = disp_r;
        end
    end

    // Anode pattern for the coming cycle; blank_mask is taken live here
    always_comb begin
        anode_nxt_s = ALL_OFF;
        if (on_nxt_s && !blank_mask[idx_nxt_s] && !lz_blank_s[idx_nxt_s]) begin
            anode_nxt_s[idx_nxt_s] = 1'b0;
        end else begin
            anode_nxt_s = ALL_OFF;
        end
    end

    // Scan, buffer and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r    <= {IW{1'b0}};
            disp_r   <= {DW{1'b0}};
            pend_r   <= {DW{1'b0}};
            pend_v_r <= 1'b0;
            anode_r  <= ALL_OFF;
            data_r   <= 4'h0;
        end else begin
            idx_r    <= idx_nxt_s;
            disp_r   <= disp_nxt_s;
            pend_r   <= pend_nxt_s;
            pend_v_r <= pend_v_nxt_s;
            anode_r  <= anode_nxt_s;
            data_r   <= disp_nxt_s[{idx_nxt_s, 2'b00} +: 4];
        end
    end

    assign data           = data_r;
    assign Anode_Activate = anode_r;
    assign digit_idx      = idx_r;
    assign pending        = pend_v_r;
    assign frame_done     = frame_done_s;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl with a 20-cycle frame (4 digits, 4 ON + 1 GAP cycles each).
module tb_sevenseg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int GC = 1;
    localparam int DP = RD + GC;
    localparam int FP = ND * DP;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  blank_mask;
    logic [3:0]  data;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;
    logic        pending;
    logic        frame_done;

    int nvec = 0;
    int nbad = 0;
    int cyc  = 0;

    int          t_m = 0;
    logic [15:0] disp_m = 16'h0;
    logic [15:0] pend_m = 16'h0;
    logic        pendv_m = 1'b0;
    logic [3:0]  blank_m = 4'h0;
    bit          valid_m = 1'b0;

    always #5 clk = ~clk;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GAP_CYCLES  (GC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .digits_in      (digits_in),
        .load           (load),
        .blank_mask     (blank_mask),
        .data           (data),
        .Anode_Activate (anode),
        .digit_idx      (digit_idx),
        .pending        (pending),
        .frame_done     (frame_done)
    );

    function automatic logic lz(input logic [15:0] w, input int d);
`ifdef SS_LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b0;
        for (int j = d; j < ND; j++) begin
            if (w[4*j +: 4] != 4'h0) return 1'b0;
        end
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, t_m, act, exp);
        end
    endtask

    // Model: position in the frame follows from cycles since reset; buffer rules applied per cycle
    initial begin
        int         pos;
        int         d;
        logic       on;
        logic [3:0] an_e;
        forever begin
            @(negedge clk);
            if (valid_m) begin
                pos  = t_m % FP;
                d    = pos / DP;
                on   = (pos % DP) >= GC;
                an_e = 4'b1111;
                if (on && !blank_m[d] && !lz(disp_m, d)) an_e[d] = 1'b0;
                check("model.anode",   16'(anode),      16'(an_e));
                check("model.data",    16'(data),       16'(disp_m[4*d +: 4]));
                check("model.idx",     16'(digit_idx),  16'(d));
                check("model.pending", 16'(pending),    16'(pendv_m));
                check("model.fdone",   16'(frame_done), 16'(pos == FP - 1));
            end
            if (reset) begin
                t_m     = 0;
                disp_m  = 16'h0;
                pend_m  = 16'h0;
                pendv_m = 1'b0;
                valid_m = 1'b1;
            end else if (valid_m) begin
                if (t_m % FP == FP - 1) begin
                    if (load) disp_m = digits_in;
                    else if (pendv_m) disp_m = pend_m;
                    pendv_m = 1'b0;
                    if (load) pend_m = digits_in;
                end else if (load) begin
                    pend_m  = digits_in;
                    pendv_m = 1'b1;
                end
                t_m++;
            end
            blank_m = blank_mask;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n);
        while (cyc < n) begin
            tick();
            cyc++;
        end
        #1;
    endtask

    task automatic pulse_load(input logic [15:0] w);
        load      = 1'b1;
        digits_in = w;
        tick();
        cyc++;
        load = 1'b0;
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        digits_in  = 16'h0;
        blank_mask = 4'h0;
        repeat (3) tick();
        reset = 1'b0;
        cyc   = 0;
        #1;
        check("rst.anode",   16'(anode),      16'h000F);
        check("rst.data",    16'(data),       16'h0000);
        check("rst.pending", 16'(pending),    16'h0000);
        check("rst.fdone",   16'(frame_done), 16'h0000);
        go(1);   check("first_on.anode", 16'(anode), 16'h000E);
        go(5);   check("gap1.anode", 16'(anode), 16'h000F); check("gap1.idx", 16'(digit_idx), 16'h0001);
        go(18);  check("fd.early", 16'(frame_done), 16'h0000);
        go(19);  check("fd.c20",   16'(frame_done), 16'h0001);

        go(25);  pulse_load(16'h1234);
        check("load.pending", 16'(pending), 16'h0001);
        go(40);  check("commit.pending", 16'(pending), 16'h0000);
        go(41);  check("f2.d0", 16'(data), 16'h4); check("f2.a0", 16'(anode), 16'h000E);
        go(46);  check("f2.d1", 16'(data), 16'h3); check("f2.a1", 16'(anode), 16'h000D);
        go(51);  check("f2.d2", 16'(data), 16'h2); check("f2.a2", 16'(anode), 16'h000B);
        go(56);  check("f2.d3", 16'(data), 16'h1); check("f2.a3", 16'(anode), 16'h0007);

        go(62);  pulse_load(16'hAAAA);
        go(65);  pulse_load(16'h5678);
        go(81);  check("lastwins.d0", 16'(data), 16'h8);
        go(86);  check("lastwins.d1", 16'(data), 16'h7);
        go(91);  check("lastwins.d2", 16'(data), 16'h6);
        go(96);  check("lastwins.d3", 16'(data), 16'h5);

        go(99);  check("bypass.fd", 16'(frame_done), 16'h0001);
        pulse_load(16'h9999);
        check("bypass.pending", 16'(pending), 16'h0000);
        go(101); check("bypass.data", 16'(data), 16'h9);

        go(105); pulse_load(16'h1234);
        go(110); blank_mask = 4'b1000;
        go(131); check("blank.d2", 16'(anode), 16'h000B);
        go(136); check("blank.d3", 16'(anode), 16'h000F);
        go(140); blank_mask = 4'b0000;

        go(145); pulse_load(16'h0042);
        go(166); check("lz42.d1", 16'(anode), 16'h000D);
`ifdef SS_LEADING_ZERO_BLANK_EN
        go(171); check("lz42.d2", 16'(anode), 16'h000F);
        go(176); check("lz42.d3", 16'(anode), 16'h000F);
`else
        go(171); check("lz42.d2", 16'(anode), 16'h000B);
        go(176); check("lz42.d3", 16'(anode), 16'h0007);
`endif
        go(185); pulse_load(16'h0000);
        go(201); check("zero.d0.anode", 16'(anode), 16'h000E); check("zero.d0.data", 16'(data), 16'h0);

        go(205); pulse_load(16'h7777);
        check("abort.pending.pre", 16'(pending), 16'h0001);
        go(212); check("abort.pre.anode", 16'(anode), 16'h000B);
        reset = 1'b1;
        tick();
        #1;
        check("abort.anode",   16'(anode),     16'h000F);
        check("abort.data",    16'(data),      16'h0000);
        check("abort.pending", 16'(pending),   16'h0000);
        check("abort.idx",     16'(digit_idx), 16'h0000);
        reset = 1'b0;
        cyc   = 0;
        go(1);   check("abort.after.anode", 16'(anode), 16'h000E); check("abort.after.data", 16'(data), 16'h0);
        go(25);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Time-multiplexing scan controller for the board's four-digit common-anode seven-segment display. It accepts a packed BCD/hex word through a load strobe and double-buffers it so updates take effect only at frame boundaries. It cycles an active-low anode select across the digits with an all-off dead time between digits, and presents the selected nibble on `data` for the existing `sevenseg` decoder.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; the anode and blank-mask width.
- `REFRESH_DIV`, 100000: clk cycles each digit is lit (ON phase); must be ≥1.
- `GAP_CYCLES`, 1000: clk cycles with all anodes off before each digit (GAP phase); must be ≥1.
- `clk` in 1: system clock; every register is updated on its rising edge.
- `reset` in 1: synchronous, active-high reset, sampled on rising `clk`.
- `digits_in` in 4*NUM_DIGITS: nibble i = `digits_in[4i+3:4i]`; digit 0 is the rightmost digit.
- `load` in 1: single-cycle strobe that captures `digits_in`.
- `blank_mask` in NUM_DIGITS: bit i=1 keeps anode i off during its ON phase; sampled live, not buffered.
- `data` out 4: nibble of the current digit, connected to `sevenseg.data`.
- `Anode_Activate` out NUM_DIGITS: active-low anode enables; at most one bit is low at any time.
- `digit_idx` out $clog2(NUM_DIGITS): index of the digit currently being scanned.
- `pending` out 1: a loaded value is waiting for commit.
- `frame_done` out 1: one-cycle pulse on the last ON cycle of digit NUM_DIGITS-1.

## Operation
- Two-state Moore FSM: GAP and ON.
  - GAP lasts GAP_CYCLES cycles, then goes to ON.
  - ON lasts REFRESH_DIV cycles, then goes to GAP and advances `digit_idx`, wrapping NUM_DIGITS-1 → 0.
- Registers:
  - `disp_q` holds the word being displayed.
  - `pend_q` and `pend_v` hold the waiting word and its valid flag.
- `load` writes `pend_q` and sets `pend_v`. A second load before commit overwrites `pend_q`; the last load wins.
- Commit happens on the `frame_done` cycle: `disp_q` takes the pending word and `pend_v` clears.
  - If `load` arrives in the same cycle, `digits_in` goes directly to `disp_q` and `pend_v` ends at 0.
  - With no pending value and no load, `disp_q` holds.
- Outputs are decoded from registered state (Moore):
  - `data = disp_q[4*digit_idx +: 4]` in both phases.
  - `Anode_Activate` is all ones in GAP. In ON it is all ones except bit `digit_idx`=0, unless that digit is blanked.
- Reset mid-frame aborts the scan immediately. There is no partial commit, and `pend_v` and the pending word are discarded.

## Timing
- Reset values: state=GAP, counter=0, `digit_idx`=0, `disp_q`=0, `pend_q`=0, `pend_v`=0. Outputs: `Anode_Activate`=all ones, `data`=4'h0, `pending`=0, `frame_done`=0.
- After the first rising edge with `reset` low:
  - GAP_CYCLES cycles of GAP, then REFRESH_DIV cycles of digit 0 lit.
  - Digit period is REFRESH_DIV+GAP_CYCLES cycles; frame period is NUM_DIGITS times that.
- `load` → `pending`=1 on the next cycle.
- A committed value is visible on `data` at digit 0 of the following frame. Worst-case latency from `load` is one frame plus one cycle.
- `blank_mask` affects the anodes on the cycle after it changes, because it is registered into the anode output.

## Configuration
- `SS_LEADING_ZERO_BLANK_EN` defined:
  - In ON, digit i is also blanked when its nibble and every more-significant nibble of `disp_q` are 0, for i>0.
  - Digit 0 is never leading-zero blanked.
  - This OR's with `blank_mask`.
- Not defined: only `blank_mask` blanks digits. No extra logic is generated.

## Structure
- `sevenseg_pkg` contains:
  - `scan_state_t` enum {GAP, ON}.
  - The default localparams for NUM_DIGITS, REFRESH_DIV and GAP_CYCLES.
  - `ANODE_OFF` function returning an all-ones mask of width n.
- Sub-module `ss_refresh_timer` implements the phase counter, with parameters ON_LEN and GAP_LEN. Its outputs are `phase_on` and `phase_last` (last cycle of the current phase).

## Test plan
Use NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1 (20-cycle frame) for all scenarios.
- Reset, then release → 1 GAP cycle with anodes 1111, then 4 cycles of 1110 with data=0. `frame_done` pulses at cycle 20.
- `load` with 16'h1234 mid-frame → `pending`=1 next cycle. The next frame shows data 4,3,2,1 with anodes 1110,1101,1011,0111; `pending` clears at `frame_done`.
- `load` 16'hAAAA, then `load` 16'h5678 before commit → the next frame shows only 8,7,6,5.
- `load` 16'h9999 on the `frame_done` cycle → the next frame starts at data=9 and `pending` stays 0.
- `blank_mask`=4'b1000 with 16'h1234 → digit 3's ON phase keeps anodes 1111. With `SS_LEADING_ZERO_BLANK_EN` and 16'h0042, digits 3 and 2 stay dark; with 16'h0000, digit 0 still lights showing 0.
- Assert `reset` during digit 2's ON phase with `pend_v`=1 → the next cycle shows anodes 1111, `data`=0, `pending`=0, `digit_idx`=0.
